// File: rtl/sume_pkg.sv
// Shared types and constants for the sample producer: FSM states, sample width, LFSR taps.
package sume_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } src_state_t;

    localparam int SAMPLE_W = 4;

    // Right-shift Galois toggle mask for x^4 + x^3 + 1 (maximal length, period 15).
    localparam logic [3:0] LFSR_TAPS_4 = 4'b1100;

endpackage

// File: rtl/sample_source_if.sv
// Sample stream valid/ready bundle; the producer uses the master modport, the consumer the slave.
interface sample_source_if
    import sume_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W
);

    logic [WIDTH-1:0] sample;
    logic             sample_valid;
    logic             sample_ready;

    modport master (
        output sample,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/sample_lfsr.sv
// Combinational Galois LFSR advance plus seed-zero guard; only built when
// SAMPLE_SOURCE_LFSR_EN is defined.
`ifdef SAMPLE_SOURCE_LFSR_EN
module sample_lfsr
    import sume_pkg::*;
#(
    parameter int               WIDTH = SAMPLE_W,
    parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS_4
) (
    input  logic [WIDTH-1:0] cur_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic [WIDTH-1:0] next_o,
    output logic [WIDTH-1:0] seed_o
);

    assign next_o = (cur_i >> 1) ^ (cur_i[0] ? TAPS : '0);

    // The all-zero state is a fixed point of the LFSR, so it can never be a seed.
    assign seed_o = (seed_i == '0) ? WIDTH'(1) : seed_i;

endmodule
`endif

// File: rtl/sample_source.sv
// Producer of a fixed-length sample run over a valid/ready interface.
// Defining SAMPLE_SOURCE_LFSR_EN adds a mode input selecting an LFSR sequence.
module sample_source
    import sume_pkg::*;
#(
    parameter int WIDTH       = SAMPLE_W,
    parameter int NUM_SAMPLES = 10,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
`ifdef SAMPLE_SOURCE_LFSR_EN
    input  logic                 mode,
`endif
    input  logic [WIDTH-1:0]     start_val,
    input  logic [WIDTH-1:0]     step,
    sample_source_if.master      src,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     beat_cnt
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_SAMPLES - 1);

    src_state_t       state_q, state_d;
    logic [WIDTH-1:0] sample_q, sample_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] first_val;
    logic [WIDTH-1:0] next_val;
    logic             xfer;

`ifdef SAMPLE_SOURCE_LFSR_EN
    logic             mode_q;
    logic [WIDTH-1:0] lfsr_next;
    logic [WIDTH-1:0] lfsr_seed;

    sample_lfsr #(.WIDTH(WIDTH)) u_lfsr (
        .cur_i  (sample_q),
        .seed_i (start_val),
        .next_o (lfsr_next),
        .seed_o (lfsr_seed)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            mode_q <= mode;
        end
    end

    assign first_val = mode ? lfsr_seed : start_val;
    assign next_val  = mode_q ? lfsr_next : sample_q + step_q;
`else
    assign first_val = start_val;
    assign next_val  = sample_q + step_q;
`endif

    assign xfer = valid_q & src.sample_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            sample_q <= '0;
            step_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            step_q   <= step_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        step_d   = step_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = STREAM;
                    sample_d = first_val;
                    step_d   = step;
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                end
            end
            STREAM: begin
                if (xfer) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // A beat accepted alongside stop still counts, but stop suppresses done.
                if (stop) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (xfer) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        sample_d = next_val;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign src.sample       = sample_q;
    assign src.sample_valid = valid_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign beat_cnt         = cnt_q;

endmodule
